// File: rtl/seq_addsub_unit.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock.
// The carry/borrow is registered between chunks; flags are registered with the final slice.
module seq_addsub_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for an operation, in_ready=1
    // RUN   | computing one chunk per cycle
    // DONE  | result and flags valid, waiting for out_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic             chain_q, chain_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   sum_c;
    logic [WIDTH-1:0] res_ins;

    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                a_c = a_q[k*CHUNK +: CHUNK];
                b_c = b_q[k*CHUNK +: CHUNK];
            end
        end

        // Bit CHUNK of the (CHUNK+1)-bit difference is set exactly when a < b + c.
        if (op_q) begin
            sum_c = {1'b0, a_c} + {1'b0, b_c} + (CHUNK+1)'(chain_q);
        end else begin
            sum_c = {1'b0, a_c} - {1'b0, b_c} - (CHUNK+1)'(chain_q);
        end

        res_ins = res_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                res_ins[k*CHUNK +: CHUNK] = sum_c[CHUNK-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        chain_d  = chain_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    a_d     = inp1;
                    b_d     = inp2;
                    op_d    = op;
                    chain_d = bin;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                res_d   = res_ins;
                chain_d = sum_c[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    borrow_d = sum_c[CHUNK];
                    zero_d   = (res_ins == '0);
                    neg_d    = res_ins[WIDTH-1];
                    if (op_q) begin
                        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_ins[WIDTH-1] != a_q[WIDTH-1]);
                    end else begin
                        ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_ins[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            chain_q  <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            chain_q  <= chain_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign result    = res_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign overflow  = ovf_q;

endmodule
